// File: rtl/rs_age_select.sv
// Shared-pool reservation station: multi-port CDB wakeup, oldest-first issue per FU type
// via an age matrix, and ROB-distance squash on branch rollback.
module rs_age_select #(
    parameter int NUM_ENTRIES  = 8,
    parameter int NUM_FU_TYPES = 4,
    parameter int NUM_CDB      = 2,
    parameter int ROB_IDX_W    = 5,
    parameter int PREG_W       = 6,
    parameter int PAYLOAD_W    = 96
) (
    input  logic                                          clock,
    input  logic                                          reset,
    input  logic                                          en,
    input  logic                                          dispatch_valid,
    output logic                                          dispatch_ready,
    input  logic [$clog2(NUM_FU_TYPES)-1:0]               dispatch_fu,
    input  logic [ROB_IDX_W-1:0]                          dispatch_rob,
    input  logic [PREG_W-1:0]                             dispatch_T,
    input  logic [PREG_W-1:0]                             dispatch_T1,
    input  logic [PREG_W-1:0]                             dispatch_T2,
    input  logic                                          dispatch_T1_rdy,
    input  logic                                          dispatch_T2_rdy,
    input  logic [PAYLOAD_W-1:0]                          dispatch_payload,
    input  logic [NUM_CDB-1:0]                            cdb_valid,
    input  logic [NUM_CDB-1:0][PREG_W-1:0]                cdb_tag,
    input  logic                                          rollback_en,
    input  logic [ROB_IDX_W-1:0]                          rollback_rob,
    input  logic [ROB_IDX_W-1:0]                          rollback_diff,
    output logic [NUM_FU_TYPES-1:0]                       issue_valid,
    input  logic [NUM_FU_TYPES-1:0]                       issue_ready,
    output logic [NUM_FU_TYPES-1:0][ROB_IDX_W-1:0]        issue_rob,
    output logic [NUM_FU_TYPES-1:0][PREG_W-1:0]           issue_T,
    output logic [NUM_FU_TYPES-1:0][PREG_W-1:0]           issue_T1,
    output logic [NUM_FU_TYPES-1:0][PREG_W-1:0]           issue_T2,
    output logic [NUM_FU_TYPES-1:0][PAYLOAD_W-1:0]        issue_payload,
    output logic [$clog2(NUM_ENTRIES):0]                  occupancy
);

    localparam int IDX_W = $clog2(NUM_ENTRIES);
    localparam int CNT_W = IDX_W + 1;
    localparam int FU_W  = $clog2(NUM_FU_TYPES);

    typedef struct packed {
        logic [FU_W-1:0]      fu;
        logic [ROB_IDX_W-1:0] rob;
        logic [PREG_W-1:0]    t;
        logic [PREG_W-1:0]    t1;
        logic                 t1_rdy;
        logic [PREG_W-1:0]    t2;
        logic                 t2_rdy;
        logic [PAYLOAD_W-1:0] payload;
    } entry_t;

    entry_t                                   r_entry [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0]                   r_valid;
    // r_age[i][j] set means entry j is older than entry i.
    logic [NUM_ENTRIES-1:0][NUM_ENTRIES-1:0]  r_age;
    logic [CNT_W-1:0]                         r_occ;

    logic [NUM_ENTRIES-1:0]                   w_eff1;
    logic [NUM_ENTRIES-1:0]                   w_eff2;
    logic [NUM_ENTRIES-1:0]                   w_squash;
    logic [NUM_ENTRIES-1:0]                   w_elig;
    logic [ROB_IDX_W-1:0]                     w_dist [NUM_ENTRIES];
    logic [NUM_FU_TYPES-1:0][NUM_ENTRIES-1:0] w_cand;
    logic [NUM_FU_TYPES-1:0][NUM_ENTRIES-1:0] w_sel;
    logic [NUM_ENTRIES-1:0]                   w_fire;
    logic [NUM_ENTRIES-1:0]                   w_free;
    logic [CNT_W-1:0]                         w_free_cnt;
    logic [IDX_W-1:0]                         w_slot;
    logic                                     w_dispatch;
    logic                                     w_new_t1_rdy;
    logic                                     w_new_t2_rdy;

    function automatic logic cdb_hit(
        input logic [PREG_W-1:0]              tag,
        input logic [NUM_CDB-1:0]             valid,
        input logic [NUM_CDB-1:0][PREG_W-1:0] tags
    );
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < NUM_CDB; k++) begin
            if (valid[k] && (tags[k] == tag)) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

    // Wakeup and squash decode per entry; d == 0 is the branch itself and survives.
    always_comb begin
        w_eff1   = '0;
        w_eff2   = '0;
        w_squash = '0;
        w_elig   = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            w_dist[i]   = r_entry[i].rob - rollback_rob;
            w_eff1[i]   = r_entry[i].t1_rdy | cdb_hit(r_entry[i].t1, cdb_valid, cdb_tag);
            w_eff2[i]   = r_entry[i].t2_rdy | cdb_hit(r_entry[i].t2, cdb_valid, cdb_tag);
            w_squash[i] = r_valid[i] & rollback_en & (w_dist[i] != '0)
                          & (w_dist[i] <= rollback_diff);
            w_elig[i]   = r_valid[i] & w_eff1[i] & w_eff2[i] & ~w_squash[i];
        end
    end

    // An entry wins its port when no older candidate for the same FU type exists.
    always_comb begin
        w_cand = '0;
        w_sel  = '0;
        for (int f = 0; f < NUM_FU_TYPES; f++) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                w_cand[f][i] = w_elig[i] & (r_entry[i].fu == FU_W'(f));
            end
        end
        for (int f = 0; f < NUM_FU_TYPES; f++) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                w_sel[f][i] = w_cand[f][i] & ~|(r_age[i] & w_cand[f]);
            end
        end
    end

    always_comb begin
        issue_valid   = '0;
        issue_rob     = '0;
        issue_T       = '0;
        issue_T1      = '0;
        issue_T2      = '0;
        issue_payload = '0;
        for (int f = 0; f < NUM_FU_TYPES; f++) begin
            issue_valid[f] = en & |w_sel[f];
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (w_sel[f][i]) begin
                    issue_rob[f]     = r_entry[i].rob;
                    issue_T[f]       = r_entry[i].t;
                    issue_T1[f]      = r_entry[i].t1;
                    issue_T2[f]      = r_entry[i].t2;
                    issue_payload[f] = r_entry[i].payload;
                end
            end
        end
    end

    always_comb begin
        w_fire     = '0;
        w_free_cnt = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            for (int f = 0; f < NUM_FU_TYPES; f++) begin
                w_fire[i] = w_fire[i] | (w_sel[f][i] & issue_valid[f] & issue_ready[f]);
            end
        end
        w_free = w_fire | (w_squash & {NUM_ENTRIES{en}});
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            w_free_cnt = w_free_cnt + CNT_W'(w_free[i]);
        end
    end

    // Slot choice looks only at start-of-cycle validity, so same-cycle frees are not reused.
    always_comb begin
        w_slot = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (!r_valid[i]) begin
                w_slot = IDX_W'(i);
            end
        end
    end

    assign dispatch_ready = en & ~rollback_en & (r_occ != CNT_W'(NUM_ENTRIES));
    assign w_dispatch     = dispatch_valid & dispatch_ready;
    assign w_new_t1_rdy   = dispatch_T1_rdy | cdb_hit(dispatch_T1, cdb_valid, cdb_tag);
    assign w_new_t2_rdy   = dispatch_T2_rdy | cdb_hit(dispatch_T2, cdb_valid, cdb_tag);
    assign occupancy      = r_occ;

    // NOTE: sequential state uses non-blocking assignments so every entry sees start-of-cycle values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_valid <= '0;
            r_age   <= '0;
            r_occ   <= '0;
        end else if (en) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (w_free[i]) begin
                    r_valid[i] <= 1'b0;
                end
                for (int j = 0; j < NUM_ENTRIES; j++) begin
                    if (w_free[i] || w_free[j]) begin
                        r_age[i][j] <= 1'b0;
                    end
                end
            end
            if (w_dispatch) begin
                r_valid[w_slot] <= 1'b1;
                r_age[w_slot]   <= r_valid & ~w_free;
            end
            r_occ <= r_occ + CNT_W'(w_dispatch) - w_free_cnt;
        end
    end

    // NOTE: entry contents carry no reset; they are only observed while the matching valid bit is set.
    always_ff @(posedge clock) begin
        if (en) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (w_dispatch && (w_slot == IDX_W'(i))) begin
                    r_entry[i].fu      <= dispatch_fu;
                    r_entry[i].rob     <= dispatch_rob;
                    r_entry[i].t       <= dispatch_T;
                    r_entry[i].t1      <= dispatch_T1;
                    r_entry[i].t1_rdy  <= w_new_t1_rdy;
                    r_entry[i].t2      <= dispatch_T2;
                    r_entry[i].t2_rdy  <= w_new_t2_rdy;
                    r_entry[i].payload <= dispatch_payload;
                end else begin
                    r_entry[i].t1_rdy  <= w_eff1[i];
                    r_entry[i].t2_rdy  <= w_eff2[i];
                end
            end
        end
    end

endmodule

// File: doc/rs_age_select.md
# rs_age_select

Parametrised reservation station for the R10000-style out-of-order core. Sits between dispatch (decoder, free list, map table) and the functional units. Holds up to NUM_ENTRIES renamed instructions in a shared pool. Its additions over a single-entry-per-FU station:

- multi-port CDB wakeup;
- oldest-first selection per FU type, with a valid/ready issue handshake;
- ROB-distance squash on branch rollback.

## Interface

Parameters:

- NUM_ENTRIES, 8: pool depth, power of two, ≥ 2.
- NUM_FU_TYPES, 4: number of issue ports, one per FU type.
- NUM_CDB, 2: number of CDB broadcast ports.
- ROB_IDX_W, 5: ROB index width.
- PREG_W, 6: physical register tag width.
- PAYLOAD_W, 96: opaque payload (inst, func, NPC, selects, branch flags, FL_idx).

Ports. Clock is `clock`; reset is `reset`, asynchronous and active-low.

- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low; clears all entries
- en  in  1  global advance; when 0, state holds, dispatch_ready=0 and all issue_valid=0
- dispatch_valid  in  1  instruction offered
- dispatch_ready  out  1  a free entry exists and no rollback this cycle
- dispatch_fu  in  $clog2(NUM_FU_TYPES)  target FU type
- dispatch_rob  in  ROB_IDX_W  ROB index
- dispatch_T  in  PREG_W  destination tag
- dispatch_T1, dispatch_T2  in  PREG_W  source tags
- dispatch_T1_rdy, dispatch_T2_rdy  in  1  source already ready
- dispatch_payload  in  PAYLOAD_W
- cdb_valid  in  NUM_CDB  broadcast valid per port
- cdb_tag  in  NUM_CDB×PREG_W  broadcast tags
- rollback_en  in  1  squash request
- rollback_rob  in  ROB_IDX_W  mispredicted branch ROB index
- rollback_diff  in  ROB_IDX_W  (ROB tail − rollback_rob) mod 2^ROB_IDX_W
- issue_valid  out  NUM_FU_TYPES  an entry is presented per FU type
- issue_ready  in  NUM_FU_TYPES  FU accepts this cycle
- issue_rob, issue_T, issue_T1, issue_T2, issue_payload  out  per port, widths as the dispatch fields
- occupancy  out  $clog2(NUM_ENTRIES)+1  valid entry count

## Operation

Each entry holds: valid, fu, rob, T, T1, T1_rdy, T2, T2_rdy, payload, and an age-matrix row.

**Wakeup.** For each source operand, eff_rdy = stored_rdy OR (some cdb_valid[k] AND cdb_tag[k] == tag).
- eff_rdy is written back every enabled cycle.
- An entry is eligible when it is valid, both eff_rdy are 1, and it is not squashed.

**Select.** For each FU type f, issue the oldest eligible entry with fu == f, decided by the age matrix.
- Outputs are combinational from state and the CDB inputs.
- Payload fields are don't-care when issue_valid[f]=0.

**Free.** At the clock edge, an entry is freed when:
- issue_valid[f] AND issue_ready[f], for its port; or
- it is squashed.

**Squash.** d = (entry.rob − rollback_rob) mod 2^ROB_IDX_W. Squash when rollback_en AND 1 ≤ d ≤ rollback_diff.
- The branch itself (d=0) survives.
- A squashed entry is never issued, even if it is eligible that cycle.

**Dispatch.** A transfer happens when dispatch_valid AND dispatch_ready.
- The instruction is written into the lowest-index entry that is free at the start of the cycle. An entry freed in the same cycle is not reused until the next cycle.
- The incoming T1_rdy/T2_rdy are ORed with same-cycle CDB matches.
- The new entry's age row marks every currently valid, non-freed entry as older.
- A newly dispatched entry cannot issue in its dispatch cycle.

**Age matrix.** NUM_ENTRIES² bits. Freeing an entry clears its row and its column.

**Occupancy.** Next value = current + dispatched − freed. Never exceeds NUM_ENTRIES and never underflows.

## Timing

- **Reset** (asserted low, asynchronous): all valid=0, age matrix 0, occupancy=0, issue_valid=0. dispatch_ready=1 from the first enabled cycle after release.
- **Issue latency:** an entry whose last source is broadcast in cycle N is presented in cycle N (same-cycle wakeup), provided it was dispatched before N.
- **Issue handshake:**
  - An unaccepted entry stays and remains eligible.
  - issue_valid may change choice between cycles if an older entry becomes eligible. No stickiness is required.
- **Full:** occupancy==NUM_ENTRIES → dispatch_ready=0, even if an issue frees an entry in the same cycle.
- **Rollback cycle:** dispatch_ready=0, and issue may proceed for non-squashed entries.
- **Wrap-around:** squash arithmetic is modulo 2^ROB_IDX_W. rollback_diff=0 squashes nothing.
- **en=0:** no state change. CDB broadcasts in that cycle are lost; the producer owns replay.

## Test plan

- Reset mid-operation with 5 entries valid → next cycle occupancy=0, all issue_valid=0, dispatch_ready=1.
- Dispatch 3 ALU ops (rob 4, 5, 6), all ready, issue_ready[ALU]=0 for 2 cycles then 1 → issue order rob 4, 5, 6 on consecutive cycles; occupancy 3→2→1→0.
- Entry with T1=12 not ready; cdb_valid=2'b10, cdb_tag[1]=12 in cycle N → issue_valid in cycle N with issue_T1=12.
- Fill 8 entries → dispatch_ready=0. Issue one → dispatch_ready=1 only on the following cycle.
- Entries rob 30, 31, 0, 1, 2; rollback_en with rollback_rob=31, diff=3 → rob 0, 1, 2 squashed; 30 and 31 kept; occupancy 5→2; no squashed entry issues that cycle.
- Two FU types, eligible entries on both, both issue_ready=1 → both issue in the same cycle; an older non-ready entry does not block a younger ready one.
